// File: rtl/down_timer_pkg.sv
// Shared types for the down_timer block: FSM state encoding and default width.
package timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/down_timer_if.sv
// Load handshake for down_timer: a start value and mode offered by a master,
// accepted by the timer whenever it is idle.
interface down_timer_if #(
  parameter int WIDTH = timer_pkg::DEF_WIDTH
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic             periodic;

  modport master (
    output load_valid,
    output load_value,
    output periodic,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_value,
    input  periodic,
    output load_ready
  );
endinterface

// File: rtl/down_timer.sv
// Loadable down-counting timer with one-shot and auto-reload modes and a
// registered one-cycle terminal-count strobe.
module down_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  down_timer_if.slave      ld,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc
);

  state_t           state;
  logic [WIDTH-1:0] reload;
  logic             mode;

  // Readiness depends on state only, so there is no input-to-output path.
  assign ld.load_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      count  <= '0;
      busy   <= 1'b0;
      tc     <= 1'b0;
      reload <= '0;
      mode   <= 1'b0;
    end else begin
      tc <= 1'b0;
      case (state)
        IDLE: begin
          if (ld.load_valid) begin
            if (ld.load_value != '0) begin
              count  <= ld.load_value;
              reload <= ld.load_value;
              mode   <= ld.periodic;
              state  <= RUN;
              busy   <= 1'b1;
            end else begin
              // A zero load expires immediately and never enters RUN.
              count <= '0;
              mode  <= 1'b0;
              tc    <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            count <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (en) begin
            if (count == WIDTH'(1)) begin
              tc <= 1'b1;
              if (mode) begin
                count <= reload;
              end else begin
                count <= '0;
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              count <= count - WIDTH'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed vector table, hand-written
// corner sequences, and randomized traffic against a behavioural model.
module tb_down_timer;

  localparam int W = 4;

  logic         clk;
  logic         rstn;
  logic         en;
  logic         abort;
  logic [W-1:0] count;
  logic         busy;
  logic         tc;

  down_timer_if #(.WIDTH(W)) ldif ();

  down_timer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .ld    (ldif.slave),
    .en    (en),
    .abort (abort),
    .count (count),
    .busy  (busy),
    .tc    (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Behavioural model: is the timer running, what it shows, what it reloads.
  bit m_run;
  int m_cnt;
  int m_rel;
  bit m_per;
  bit m_tc;

  typedef struct {
    bit lvalid;
    int lval;
    bit per;
    bit en;
    bit ab;
    int exp_cnt;
    bit exp_busy;
    bit exp_tc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_rel = 0; m_per = 0; m_tc = 0;
  endtask

  task automatic model_edge(input bit lvld, input int lval, input bit per,
                            input bit e, input bit ab);
    m_tc = 0;
    if (!m_run) begin
      if (lvld) begin
        if (lval != 0) begin
          m_run = 1; m_cnt = lval; m_rel = lval; m_per = per;
        end else begin
          m_cnt = 0; m_tc = 1; m_per = 0;
        end
      end
    end else if (ab) begin
      m_run = 0; m_cnt = 0;
    end else if (e) begin
      if (m_cnt == 1) begin
        m_tc = 1;
        if (m_per) m_cnt = m_rel;
        else begin m_cnt = 0; m_run = 0; end
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
  endtask

  // Apply one cycle of inputs, clock it, and sample #1 after the edge.
  task automatic step(input bit lvld, input int lval, input bit per,
                      input bit e, input bit ab);
    ldif.load_valid = lvld;
    ldif.load_value = W'(lval);
    ldif.periodic   = per;
    en              = e;
    abort           = ab;
    @(posedge clk);
    model_edge(lvld, lval, per, e, ab);
    #1;
  endtask

  task automatic chk_out(input string nm, input int c, input bit b, input bit t);
    chk({nm, ".count"}, int'(count), c);
    chk({nm, ".busy"}, int'(busy), int'(b));
    chk({nm, ".tc"}, int'(tc), int'(t));
    chk({nm, ".ready"}, int'(ldif.load_ready), int'(!b));
  endtask

  task automatic add(input bit lv, input int val, input bit p, input bit e,
                     input bit a, input int c, input bit b, input bit t);
    vec_t v;
    v.lvalid = lv; v.lval = val; v.per = p; v.en = e; v.ab = a;
    v.exp_cnt = c; v.exp_busy = b; v.exp_tc = t;
    tbl.push_back(v);
  endtask

  initial begin
    int tc_at;
    rstn = 1'b0;
    ldif.load_valid = 1'b0;
    ldif.load_value = '0;
    ldif.periodic   = 1'b0;
    en    = 1'b0;
    abort = 1'b0;
    model_reset();

    // One-shot 3, load_valid ignored while running
    add(1, 3, 0, 1, 0, 3, 1, 0);
    add(1, 7, 1, 1, 0, 2, 1, 0);
    add(0, 0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    // Periodic 2 for 7 cycles, then abort
    add(1, 2, 1, 1, 0, 2, 1, 0);
    add(0, 0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 0, 1, 0, 2, 1, 1);
    add(0, 0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 0, 1, 0, 2, 1, 1);
    add(0, 0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 0, 1, 0, 2, 1, 1);
    add(0, 0, 0, 1, 1, 0, 0, 0);
    // Load 5, en low for two cycles at count 3
    add(1, 5, 0, 1, 0, 5, 1, 0);
    add(0, 0, 0, 1, 0, 4, 1, 0);
    add(0, 0, 0, 1, 0, 3, 1, 0);
    add(0, 0, 0, 0, 0, 3, 1, 0);
    add(0, 0, 0, 0, 0, 3, 1, 0);
    add(0, 0, 0, 1, 0, 2, 1, 0);
    add(0, 0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 1);
    // Zero load: immediate tc, never busy
    add(1, 0, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    // Abort and en together at count 1
    add(1, 2, 0, 1, 0, 2, 1, 0);
    add(0, 0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #1;
    chk_out("rst", 0, 0, 0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].lvalid, tbl[i].lval, tbl[i].per, tbl[i].en, tbl[i].ab);
      chk_out($sformatf("tbl%0d", i), tbl[i].exp_cnt, tbl[i].exp_busy, tbl[i].exp_tc);
    end

    // Asynchronous reset at count 5 takes effect without a clock edge
    step(1, 7, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk_out("pre_rst", 5, 1, 0);
    #2;
    rstn = 1'b0;
    #1;
    chk_out("async_rst", 0, 0, 0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    step(0, 0, 0, 1, 0);
    chk_out("post_rst", 0, 0, 0);

    // Load 15, abort at count 4 with load_valid high
    step(1, 15, 0, 1, 0);
    chk_out("ab15.load", 15, 1, 0);
    for (int i = 0; i < 11; i++) step(0, 0, 0, 1, 0);
    chk_out("ab15.at4", 4, 1, 0);
    step(1, 9, 0, 1, 1);
    chk_out("ab15.abort", 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk_out("ab15.noload", 0, 0, 0);

    // Max load: tc exactly 15 cycles after accept, bounded wait
    step(1, 15, 0, 1, 0);
    tc_at = -1;
    for (int i = 1; i <= 20 && tc_at < 0; i++) begin
      step(0, 0, 0, 1, 0);
      if (tc) tc_at = i;
    end
    chk("max.tc_delay", tc_at, 15);
    chk_out("max.end", 0, 0, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bit lv, p, e, a;
      int val;
      lv  = ($urandom_range(0, 3) == 0);
      val = $urandom_range(0, 15);
      if ($urandom_range(0, 7) == 0) val = 0;
      p   = $urandom_range(0, 1);
      e   = ($urandom_range(0, 4) != 0);
      a   = ($urandom_range(0, 24) == 0);
      step(lv, val, p, e, a);
      chk_out($sformatf("rnd%0d", i), m_cnt, m_run, m_tc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
